// File: rtl/mlp_mac_pipe.sv
// Pipelined signed multiply-accumulate for MLP dot products: framed vectors,
// saturating accumulation, rounded fixed-point rescale and output saturation.
module mlp_mac_pipe #(
    parameter int A_W        = 18,
    parameter int B_W        = 18,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 18,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    localparam int P_W    = A_W + B_W;
    localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    // Half an output LSB; zero when no fractional bits are dropped.
    localparam logic signed [ACC_W-1:0] RND =
        (FRAC_SHIFT > 0) ? ({{(ACC_W-1){1'b0}}, 1'b1} << RND_SH) : '0;

    // Returns {clipped, sum} with the sum held to the accumulator range.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                               input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W:0] s;
        s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    // Returns {clipped, value} with the value held to the output range.
    function automatic logic [OUT_W:0] sat_out(input logic signed [ACC_W-1:0] r);
        if (r > OUT_MAX)
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        if (r < OUT_MIN)
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic signed [A_W-1:0]   a_p1;
    logic signed [B_W-1:0]   b_p1;
    logic                    vld_p1, first_p1, last_p1;
    logic signed [P_W-1:0]   prod_p2;
    logic                    vld_p2, first_p2, last_p2;
    logic signed [ACC_W-1:0] acc_p3;
    logic                    ovf_p3, vld_p3;

    logic signed [ACC_W-1:0] prod_ext, acc_base, rnd_val, shifted;
    logic        [ACC_W:0]   acc_sum, rnd_sum;
    logic        [OUT_W:0]   out_nxt;

    always_comb begin
        prod_ext = ACC_W'(prod_p2);
        acc_base = first_p2 ? '0 : acc_p3;
        acc_sum  = sat_add(acc_base, prod_ext);
        rnd_sum  = sat_add(acc_p3, RND);
        rnd_val  = rnd_sum[ACC_W-1:0];
        shifted  = rnd_val >>> FRAC_SHIFT;
        out_nxt  = sat_out(shifted);
    end

    // S1: operand and flag capture; S2: full-precision product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_p1     <= '0;
            b_p1     <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            prod_p2  <= '0;
            vld_p2   <= 1'b0;
            first_p2 <= 1'b0;
            last_p2  <= 1'b0;
        end else if (ce) begin
            a_p1     <= a;
            b_p1     <= b;
            vld_p1   <= in_valid;
            first_p1 <= in_first;
            last_p1  <= in_last;
            prod_p2  <= P_W'(a_p1) * P_W'(b_p1);
            vld_p2   <= vld_p1;
            first_p2 <= first_p1;
            last_p2  <= last_p1;
        end
    end

    // S3: accumulate; overflow stays sticky until the next first term
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p3 <= '0;
            ovf_p3 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (ce) begin
            vld_p3 <= vld_p2 & last_p2;
            if (vld_p2) begin
                acc_p3 <= acc_sum[ACC_W-1:0];
                ovf_p3 <= (ovf_p3 & ~first_p2) | acc_sum[ACC_W];
            end
        end
    end

    // S4: rescale, round and saturate on vector completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            out_valid <= vld_p3;
            if (vld_p3) begin
                out_data <= out_nxt[OUT_W-1:0];
                out_sat  <= ovf_p3 | rnd_sum[ACC_W] | out_nxt[OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_mlp_mac_pipe.sv
// Directed bench for mlp_mac_pipe: table of single-term vectors plus
// hand-written framing, stall, overflow and reset sequences.
module tb_mlp_mac_pipe;

    localparam int A_W        = 18;
    localparam int B_W        = 18;
    localparam int ACC_W      = 40;
    localparam int OUT_W      = 18;
    localparam int FRAC_SHIFT = 8;

    logic                    clk      = 1'b0;
    logic                    reset    = 1'b0;
    logic                    ce       = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_first = 1'b0;
    logic                    in_last  = 1'b0;
    logic signed [A_W-1:0]   a        = '0;
    logic signed [B_W-1:0]   b        = '0;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;

    int n_cmp     = 0;
    int n_err     = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    mlp_mac_pipe #(
        .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a), .b(b),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
    );

    typedef struct {
        int   a;
        int   b;
        int   d;
        logic s;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl[NV];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Counts ce-cycles in which out_valid is high, sampled before each edge.
    task automatic tick();
        if (ce && out_valid) pulse_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic l, input int av, input int bv);
        in_valid = v;
        in_first = f;
        in_last  = l;
        a        = A_W'(av);
        b        = B_W'(bv);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic term(input logic f, input logic l, input int av, input int bv);
        drive(1'b1, f, l, av, bv);
        tick();
        idle();
    endtask

    task automatic expect_out(input string name, input int lat, input int d, input logic s);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, lat);
        check({name, " data"}, out_data, d);
        check({name, " sat"}, out_sat, s);
    endtask

    task automatic finish_pulse(input string name);
        tick();
        check({name, " valid_drop"}, out_valid, 0);
        check({name, " pulses"}, pulse_cnt, 1);
    endtask

    initial begin
        tbl[0]  = '{256, 512, 512, 1'b0};
        tbl[1]  = '{-131072, -131072, 131071, 1'b1};
        tbl[2]  = '{-131072, 131071, -131072, 1'b1};
        tbl[3]  = '{1, 128, 1, 1'b0};
        tbl[4]  = '{-1, 128, 0, 1'b0};
        tbl[5]  = '{-3, 128, -1, 1'b0};
        tbl[6]  = '{2, 256, 2, 1'b0};
        tbl[7]  = '{1, 127, 0, 1'b0};
        tbl[8]  = '{3, -128, -1, 1'b0};
        tbl[9]  = '{131071, 256, 131071, 1'b0};
        tbl[10] = '{-131072, 256, -131072, 1'b0};

        repeat (2) tick();
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sat", out_sat, 0);
        reset = 1'b1;
        ce    = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            pulse_cnt = 0;
            term(1'b1, 1'b1, tbl[i].a, tbl[i].b);
            expect_out($sformatf("vec%0d", i), 3, tbl[i].d, tbl[i].s);
            finish_pulse($sformatf("vec%0d", i));
        end

        // Three terms back to back.
        pulse_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 256, 256);  tick();
        drive(1'b1, 1'b0, 1'b0, -512, 256); tick();
        drive(1'b1, 1'b0, 1'b1, 768, 256);  tick();
        idle();
        expect_out("three", 3, 512, 1'b0);
        finish_pulse("three");

        // Same vector with bubbles, one carrying stray flags.
        pulse_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 256, 256);  tick();
        idle();                             tick();
        drive(1'b1, 1'b0, 1'b0, -512, 256); tick();
        drive(1'b0, 1'b1, 1'b1, 5, 5);      tick();
        idle();                             tick();
        drive(1'b1, 1'b0, 1'b1, 768, 256);  tick();
        idle();
        expect_out("bubble", 3, 512, 1'b0);
        finish_pulse("bubble");

        // A new first term drops the partial vector.
        pulse_cnt = 0;
        term(1'b1, 1'b0, 1000, 256);
        term(1'b1, 1'b1, 4, 256);
        expect_out("restart", 3, 4, 1'b0);
        finish_pulse("restart");

        // Stall between terms 2 and 3, and again with the result in S3.
        pulse_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 256, 256);  tick();
        drive(1'b1, 1'b0, 1'b0, -512, 256); tick();
        ce = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 999, 999);
        repeat (3) tick();
        ce = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 768, 256);  tick();
        idle();
        tick();
        tick();
        ce = 1'b0;
        tick();
        check("stall s3 valid a", out_valid, 0);
        tick();
        check("stall s3 valid b", out_valid, 0);
        ce = 1'b1;
        tick();
        check("stall out_valid", out_valid, 1);
        check("stall out_data", out_data, 512);
        check("stall out_sat", out_sat, 0);
        ce = 1'b0;
        tick();
        tick();
        check("stall hold valid", out_valid, 1);
        check("stall hold data", out_data, 512);
        ce = 1'b1;
        finish_pulse("stall");

        // Accumulator clips high, then comes down to -1; flag stays sticky.
        pulse_cnt = 0;
        for (int k = 0; k < 97; k++) begin
            if (k < 33) drive(1'b1, k == 0, 1'b0, -131072, -131072);
            else        drive(1'b1, 1'b0, k == 96, -131072, 65536);
            tick();
        end
        idle();
        expect_out("acc_ovf", 3, 0, 1'b1);
        finish_pulse("acc_ovf");
        pulse_cnt = 0;
        term(1'b1, 1'b1, 1, 128);
        expect_out("ovf_clear", 3, 1, 1'b0);
        finish_pulse("ovf_clear");

        // Reset in the middle of a vector.
        pulse_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 256, 256); tick();
        drive(1'b1, 1'b0, 1'b0, 256, 256); tick();
        idle();
        reset = 1'b0;
        #1;
        check("async rst out_data", out_data, 0);
        check("async rst out_valid", out_valid, 0);
        tick();
        reset = 1'b1;
        term(1'b1, 1'b1, 2, 256);
        expect_out("rst_vec", 3, 2, 1'b0);
        finish_pulse("rst_vec");

        // After reset, a last term without a first accumulates onto zero.
        pulse_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 1000, 256); tick();
        idle();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        term(1'b0, 1'b1, 1, 256);
        expect_out("last_only", 3, 1, 1'b0);
        finish_pulse("last_only");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
